// File: rtl/gb_sound_mixer.sv
// Game Boy four-channel stereo mixer feeding AC97 slots 3/4, sampled once per frame strobe.
// Optional build macro MIXER_HPF_EN adds a per-side DC-blocking high-pass at the output register.
module gb_sound_mixer #(
  parameter logic [15:0] ADDR_NR50 = 16'hFF24,
  parameter logic [15:0] ADDR_NR51 = 16'hFF25,
  parameter logic [15:0] ADDR_NR52 = 16'hFF26
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_STROBE,
  input  logic [15:0] I_IOREG_ADDR,
  inout  wire  [7:0]  IO_IOREG_DATA,
  input  logic        I_IOREG_WE_L,
  input  logic        I_IOREG_RE_L,
  input  logic [3:0]  I_CH1_AMP,
  input  logic [3:0]  I_CH2_AMP,
  input  logic [3:0]  I_CH3_AMP,
  input  logic [3:0]  I_CH4_AMP,
  input  logic [3:0]  I_CH_ON,
  output logic [19:0] O_LEFT,
  output logic [19:0] O_RIGHT,
  output logic        O_VALID
);

  logic [7:0] nr50_q;
  logic [7:0] nr51_q;
  logic       master_q;

  logic sel_nr50, sel_nr51, sel_nr52;
  assign sel_nr50 = (I_IOREG_ADDR == ADDR_NR50);
  assign sel_nr51 = (I_IOREG_ADDR == ADDR_NR51);
  assign sel_nr52 = (I_IOREG_ADDR == ADDR_NR52);

  // Register file: clearing master wipes routing and volume on the same edge.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      nr50_q   <= 8'h00;
      nr51_q   <= 8'h00;
      master_q <= 1'b0;
    end else if (!I_IOREG_WE_L) begin
      if (sel_nr52) begin
        master_q <= IO_IOREG_DATA[7];
        if (!IO_IOREG_DATA[7]) begin
          nr50_q <= 8'h00;
          nr51_q <= 8'h00;
        end
      end else if (sel_nr50 && master_q) begin
        nr50_q <= IO_IOREG_DATA;
      end else if (sel_nr51 && master_q) begin
        nr51_q <= IO_IOREG_DATA;
      end
    end
  end

  logic [7:0] rd_data;
  logic       rd_en;

  always_comb begin
    rd_data = 8'h00;
    rd_en   = 1'b0;
    if (!I_IOREG_RE_L) begin
      if (sel_nr50) begin
        rd_data = nr50_q;
        rd_en   = 1'b1;
      end else if (sel_nr51) begin
        rd_data = nr51_q;
        rd_en   = 1'b1;
      end else if (sel_nr52) begin
        rd_data = {master_q, 3'b111, I_CH_ON};
        rd_en   = 1'b1;
      end
    end
  end

  assign IO_IOREG_DATA = rd_en ? rd_data : 8'hzz;

  // DAC code 0..15 maps to -15..+15 in odd steps.
  function automatic logic signed [6:0] dac_level(input logic [3:0] amp);
    return $signed({2'b00, amp, 1'b0}) - 7'sd15;
  endfunction

  function automatic logic [19:0] scale(input logic signed [6:0] s, input logic [2:0] vol,
                                        input logic on);
    logic signed [9:0] p;
    p = $signed({{3{s[6]}}, s}) * $signed({6'd0, {1'b0, vol} + 4'd1});
    return on ? {p, 10'd0} : 20'd0;
  endfunction

  logic signed [6:0] dac [4];
  logic signed [6:0] sum_l, sum_r;

  always_comb begin
    dac[0] = dac_level(I_CH1_AMP);
    dac[1] = dac_level(I_CH2_AMP);
    dac[2] = dac_level(I_CH3_AMP);
    dac[3] = dac_level(I_CH4_AMP);
    sum_l  = 7'sd0;
    sum_r  = 7'sd0;
    for (int n = 0; n < 4; n++) begin
      if (nr51_q[4+n]) sum_l = sum_l + dac[n];
      if (nr51_q[n])   sum_r = sum_r + dac[n];
    end
  end

  // Stage 1 carries volume and master alongside the sums so a setting change moves as one unit.
  logic signed [6:0] s1_l_q, s1_r_q;
  logic [2:0]        s1_vl_q, s1_vr_q;
  logic              s1_on_q;
  logic [19:0]       s2_l_q, s2_r_q;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      s1_l_q  <= 7'sd0;
      s1_r_q  <= 7'sd0;
      s1_vl_q <= 3'd0;
      s1_vr_q <= 3'd0;
      s1_on_q <= 1'b0;
      s2_l_q  <= 20'h0;
      s2_r_q  <= 20'h0;
    end else begin
      s1_l_q  <= sum_l;
      s1_r_q  <= sum_r;
      s1_vl_q <= nr50_q[6:4];
      s1_vr_q <= nr50_q[2:0];
      s1_on_q <= master_q;
      s2_l_q  <= scale(s1_l_q, s1_vl_q, s1_on_q);
      s2_r_q  <= scale(s1_r_q, s1_vr_q, s1_on_q);
    end
  end

  logic [19:0] out_l_q, out_r_q;
  logic        valid_q;

`ifdef MIXER_HPF_EN
  // One-pole DC blocker: c tracks 256x the running mean, y removes it.
  logic signed [27:0] c_l_q, c_r_q;
  logic signed [20:0] diff_l, diff_r;

  function automatic logic [19:0] sat20(input logic signed [20:0] d);
    if (d[20] != d[19]) return d[20] ? 20'h80000 : 20'h7FFFF;
    return d[19:0];
  endfunction

  always_comb begin
    diff_l = $signed({s2_l_q[19], s2_l_q}) - $signed({c_l_q[27], c_l_q[27:8]});
    diff_r = $signed({s2_r_q[19], s2_r_q}) - $signed({c_r_q[27], c_r_q[27:8]});
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      out_l_q <= 20'h0;
      out_r_q <= 20'h0;
      valid_q <= 1'b0;
      c_l_q   <= 28'sd0;
      c_r_q   <= 28'sd0;
    end else begin
      valid_q <= I_STROBE;
      if (I_STROBE) begin
        out_l_q <= sat20(diff_l);
        out_r_q <= sat20(diff_r);
      end
      if (!master_q) begin
        c_l_q <= 28'sd0;
        c_r_q <= 28'sd0;
      end else if (I_STROBE) begin
        c_l_q <= c_l_q + {{7{diff_l[20]}}, diff_l};
        c_r_q <= c_r_q + {{7{diff_r[20]}}, diff_r};
      end
    end
  end
`else
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      out_l_q <= 20'h0;
      out_r_q <= 20'h0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= I_STROBE;
      if (I_STROBE) begin
        out_l_q <= s2_l_q;
        out_r_q <= s2_r_q;
      end
    end
  end
`endif

  assign O_LEFT  = out_l_q;
  assign O_RIGHT = out_r_q;
  assign O_VALID = valid_q;

endmodule

// File: tb/tb_gb_sound_mixer.sv
// Self-checking bench for gb_sound_mixer: vector table, randomized model comparison, corner cases.
module tb_gb_sound_mixer;

  localparam logic [15:0] ADDR_NR50 = 16'hFF24;
  localparam logic [15:0] ADDR_NR51 = 16'hFF25;
  localparam logic [15:0] ADDR_NR52 = 16'hFF26;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [15:0] addr;
  wire  [7:0]  bus;
  logic [7:0]  tb_data;
  logic        tb_oe;
  logic        we_l, re_l;
  logic [3:0]  ch1, ch2, ch3, ch4, ch_on;
  logic [19:0] o_left, o_right;
  logic        o_valid;

  int checks = 0;
  int failures = 0;

  assign bus = tb_oe ? tb_data : 8'hzz;

  always #5 clk = ~clk;

  gb_sound_mixer #(
    .ADDR_NR50(ADDR_NR50),
    .ADDR_NR51(ADDR_NR51),
    .ADDR_NR52(ADDR_NR52)
  ) dut (
    .I_CLK        (clk),
    .I_RESET      (rst),
    .I_STROBE     (strobe),
    .I_IOREG_ADDR (addr),
    .IO_IOREG_DATA(bus),
    .I_IOREG_WE_L (we_l),
    .I_IOREG_RE_L (re_l),
    .I_CH1_AMP    (ch1),
    .I_CH2_AMP    (ch2),
    .I_CH3_AMP    (ch3),
    .I_CH4_AMP    (ch4),
    .I_CH_ON      (ch_on),
    .O_LEFT       (o_left),
    .O_RIGHT      (o_right),
    .O_VALID      (o_valid)
  );

  typedef struct {
    logic [7:0]  nr50;
    logic [7:0]  nr51;
    logic [15:0] amps;  // {ch4, ch3, ch2, ch1}
    logic [19:0] exp_l;
    logic [19:0] exp_r;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr    = a;
    tb_data = d;
    tb_oe   = 1'b1;
    we_l    = 1'b0;
    tick();
    we_l    = 1'b1;
    tb_oe   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    addr = a;
    re_l = 1'b0;
    #1;
    d    = bus;
    re_l = 1'b1;
    #1;
  endtask

  task automatic set_amps(input logic [15:0] amps);
    {ch4, ch3, ch2, ch1} = amps;
  endtask

  task automatic apply(input logic [7:0] n50, input logic [7:0] n51, input logic [15:0] amps);
    wr(ADDR_NR50, n50);
    wr(ADDR_NR51, n51);
    set_amps(amps);
    repeat (3) tick();
  endtask

  // Single strobe; checks the one-cycle O_VALID pulse and the loaded samples.
  task automatic strobe_check(input string name, input logic [19:0] el, input logic [19:0] er);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    check({name, "_valid"}, {19'd0, o_valid}, 20'd1);
    check({name, "_left"}, o_left, el);
    check({name, "_right"}, o_right, er);
    tick();
    check({name, "_valid_drop"}, {19'd0, o_valid}, 20'd0);
  endtask

  // Reference: mix from the register fields with plain integer arithmetic.
  function automatic logic [19:0] model(input logic [7:0] nr50, input logic [7:0] nr51,
                                        input logic [15:0] amps, input bit left);
    int s, v, a;
    s = 0;
    for (int n = 0; n < 4; n++) begin
      a = int'(amps[4*n +: 4]);
      if (left ? nr51[4+n] : nr51[n]) s += 2 * a - 15;
    end
    v = left ? int'(nr50[6:4]) : int'(nr50[2:0]);
    return 20'(s * (v + 1) * 1024);
  endfunction

  initial begin
    logic [7:0]  rdv;
    logic [7:0]  n50, n51;
    logic [15:0] amps;
    int          sl, sr;

    vecs[0] = '{8'h77, 8'h11, 16'h000F, 20'h1E000, 20'h1E000};
    vecs[1] = '{8'h77, 8'h11, 16'h0000, 20'hE2000, 20'hE2000};
    vecs[2] = '{8'h77, 8'hFF, 16'hFFFF, 20'h78000, 20'h78000};
    vecs[3] = '{8'h70, 8'hFF, 16'hFFFF, 20'h78000, 20'h0F000};
    vecs[4] = '{8'h77, 8'h10, 16'h000F, 20'h1E000, 20'h00000};
    vecs[5] = '{8'h07, 8'h0F, 16'h0000, 20'h00000, 20'h88000};
    vecs[6] = '{8'h00, 8'hF0, 16'h0000, 20'hF1000, 20'h00000};

    rst = 1'b1; strobe = 1'b0; addr = 16'h0; tb_data = 8'h0; tb_oe = 1'b0;
    we_l = 1'b1; re_l = 1'b1; ch_on = 4'b1010;
    set_amps(16'h0000);
    repeat (3) tick();
    rst = 1'b0;

    check("reset_left", o_left, 20'h0);
    check("reset_right", o_right, 20'h0);
    check("reset_valid", {19'd0, o_valid}, 20'd0);
    for (int i = 0; i < 3; i++) strobe_check("reset_strobe", 20'h0, 20'h0);
    rd(ADDR_NR52, rdv);
    check("nr52_reset", rdv, 8'h7A);
    rd(ADDR_NR50, rdv);
    check("nr50_reset", rdv, 8'h00);

    wr(ADDR_NR52, 8'h80);
    rd(ADDR_NR52, rdv);
    check("nr52_on", rdv, 8'hFA);

`ifdef MIXER_HPF_EN
    apply(8'h77, 8'hFF, 16'hFFFF);
    strobe_check("hpf_first", 20'h78000, 20'h78000);
    strobe = 1'b1;
    repeat (2047) tick();
    strobe = 1'b0;
    tick();
    sl = $signed(o_left);
    sr = $signed(o_right);
    check("hpf_decay_left", {19'd0, (sl < 1024 && sl > -1024)}, 20'd1);
    check("hpf_decay_right", {19'd0, (sr < 1024 && sr > -1024)}, 20'd1);
`else
    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].nr50, vecs[i].nr51, vecs[i].amps);
      rd(ADDR_NR50, rdv);
      check($sformatf("vec%0d_nr50_rb", i), rdv, vecs[i].nr50);
      rd(ADDR_NR51, rdv);
      check($sformatf("vec%0d_nr51_rb", i), rdv, vecs[i].nr51);
      strobe_check($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r);
    end

    for (int i = 0; i < 40; i++) begin
      n50  = 8'($urandom);
      n51  = 8'($urandom);
      amps = 16'($urandom);
      apply(n50, n51, amps);
      strobe_check($sformatf("rand%0d", i), model(n50, n51, amps, 1'b1),
                   model(n50, n51, amps, 1'b0));
    end

    // Output hold: input changes must not reach the output without a strobe.
    apply(8'h77, 8'h11, 16'h000F);
    strobe_check("hold_setup", 20'h1E000, 20'h1E000);
    set_amps(16'h0000);
    repeat (6) begin
      tick();
      check("hold_left", o_left, 20'h1E000);
      check("hold_valid", {19'd0, o_valid}, 20'd0);
    end

    // Strobe coincident with a volume write, then a back-to-back strobe: both see old setting.
    set_amps(16'h000F);
    repeat (3) tick();
    strobe = 1'b1;
    wr(ADDR_NR50, 8'h00);
    check("simul_left", o_left, 20'h1E000);
    check("simul_valid", {19'd0, o_valid}, 20'd1);
    tick();
    strobe = 1'b0;
    check("b2b_left", o_left, 20'h1E000);
    check("b2b_valid", {19'd0, o_valid}, 20'd1);
    repeat (3) tick();
    strobe_check("new_vol", 20'h03C00, 20'h03C00);

    // Master off clears settings and blocks further writes.
    wr(ADDR_NR52, 8'h00);
    rd(ADDR_NR50, rdv);
    check("off_nr50", rdv, 8'h00);
    rd(ADDR_NR51, rdv);
    check("off_nr51", rdv, 8'h00);
    rd(ADDR_NR52, rdv);
    check("off_nr52", rdv, 8'h7A);
    repeat (3) tick();
    strobe_check("off_out", 20'h0, 20'h0);
    wr(ADDR_NR50, 8'h77);
    rd(ADDR_NR50, rdv);
    check("off_wr_ignored", rdv, 8'h00);

    // Reset wins over a coincident strobe.
    wr(ADDR_NR52, 8'h80);
    apply(8'h77, 8'hFF, 16'hFFFF);
    strobe_check("pre_reset", 20'h78000, 20'h78000);
    rst = 1'b1;
    strobe = 1'b1;
    tick();
    rst = 1'b0;
    strobe = 1'b0;
    check("midrst_left", o_left, 20'h0);
    check("midrst_right", o_right, 20'h0);
    check("midrst_valid", {19'd0, o_valid}, 20'd0);
    tick();
    check("midrst_valid_after", {19'd0, o_valid}, 20'd0);
    sl = 0;
    sr = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_sound_mixer.md
Name: gb_sound_mixer

Overview:
Stereo mixer stage directly upstream of the AC-link frame generator. It combines the four Game Boy channel amplitudes under the NR50/NR51/NR52 register controls. Each side becomes a signed 20-bit PCM sample, held steady for the left (slot 3) and right (slot 4) AC97 slots. The sample register updates once per AC97 frame, on the frame strobe.

Parameters:
ADDR_NR50, 16'hFF24, master volume / Vin register address
ADDR_NR51, 16'hFF25, channel-to-side routing register address
ADDR_NR52, 16'hFF26, sound master enable / status register address

Ports:
I_CLK  in  1  system clock; all logic on rising edge
I_RESET  in  1  synchronous, active-high reset
I_STROBE  in  1  one-cycle frame pulse, already synchronous to I_CLK
I_IOREG_ADDR  in  16  CPU IO register address
IO_IOREG_DATA  inout  8  CPU IO data bus
I_IOREG_WE_L  in  1  active-low write enable
I_IOREG_RE_L  in  1  active-low read enable
I_CH1_AMP, I_CH2_AMP, I_CH3_AMP, I_CH4_AMP  in  4 each  channel DAC codes, 0..15
I_CH_ON  in  4  channel-active flags [3]=ch4..[0]=ch1, status readback only
O_LEFT  out  20  signed left sample, slot 3 format
O_RIGHT  out  20  signed right sample, slot 4 format
O_VALID  out  1  one-cycle pulse when O_LEFT/O_RIGHT update

Behaviour:
- Reset (I_RESET high at a clock edge):
  - NR50=8'h00, NR51=8'h00, master=0.
  - Pipeline registers, O_LEFT and O_RIGHT = 20'h0; O_VALID=0.
- Register writes: take effect at the edge where WE_L=0 and the address matches.
  - NR52 write: only bit7 is stored, into master.
  - Writing master=0: NR50 and NR51 clear to 0 on the same edge.
  - NR50/NR51 writes while master=0 are ignored.
  - A write to NR52 with bit7=0 and a simultaneous write to NR50 is impossible (single bus).
- Register reads: when RE_L=0 and the address matches, drive the bus combinationally; otherwise drive 8'hZZ.
  - NR50 and NR51 read back their stored values.
  - NR52 reads {master, 3'b111, I_CH_ON}.
- Routing and volume fields:
  - NR51[4+n] routes channel n+1 to left; NR51[n] routes it to right.
  - NR50[6:4] is left volume VL, NR50[2:0] is right volume VR. Bits 7 and 3 (Vin) are stored but ignored.
- Arithmetic per side:
  - d_n = 2*amp_n - 15, signed 5-bit, range -15..+15.
  - S = sum of routed d_n, signed 7-bit, -60..+60; S = 0 if nothing is routed.
  - P = S*(V+1), signed 10-bit, -480..+480.
  - Sample = sign-extend(P) << 10, giving 20-bit signed ±491520; no overflow is possible.
  - If master=0, the sample is forced to 0.
- Pipeline:
  - Stage 1 registers S for both sides every cycle.
  - Stage 2 registers the scaled sample every cycle.
  - Output register loads stage 2 only on I_STROBE.
  - Latency from an input change to stage-2 valid is 2 cycles; visible at the output on the first strobe at least 2 cycles later.
- O_VALID: asserts the cycle after the loading strobe edge, for exactly 1 cycle. Back-to-back strobes give back-to-back pulses.
- Output hold: O_LEFT/O_RIGHT are held between strobes and never change except on a strobe edge or reset.
- Simultaneous strobe and register write: the output takes the stage-2 value from before the write. The new setting appears no earlier than 2 strobes-or-cycles later, as per the pipeline.
- Reset mid-operation: reset overrides strobe; outputs go to 0 and O_VALID=0 on that edge.

Optional Feature:
MIXER_HPF_EN: DC-blocking high-pass filter per side, applied at the output register.
- Defined:
  - Each side keeps a 28-bit signed accumulator c, reset to 0.
  - On each strobe: y = x - c[27:8], then c <= c + (x - c[27:8]). O_LEFT/O_RIGHT = y, saturated to 20-bit signed.
  - master=0 also clears c.
  - Constant input decays toward 0 with a time constant of about 256 frames.
- Undefined: y = x directly; no accumulator logic is synthesised.

Test Plan:
- Reset, then 3 strobes -> O_LEFT=O_RIGHT=20'h0; O_VALID pulses 1 cycle after each strobe; NR52 reads 8'h70 | I_CH_ON.
- NR52=8'h80, NR50=8'h77, NR51=8'h11, CH1_AMP=15, others 0, strobe -> O_LEFT=O_RIGHT=20'h1E000.
- Same setup with CH1_AMP=0 -> both outputs 20'hE2000 (-122880).
- NR51=8'hFF, NR50=8'h77, all AMPs 15 -> both 20'h78000. Then NR50=8'h70 -> O_RIGHT=20'h0F000, O_LEFT unchanged.
- NR51=8'h10, CH1_AMP=15 -> O_LEFT=20'h1E000, O_RIGHT=20'h0. Write NR52=8'h00 -> NR50/NR51 read 8'h00, next strobe outputs 0. Write NR50=8'h77 while off -> reads 8'h00.
- With MIXER_HPF_EN: constant full-scale input, 2048 strobes -> |O_LEFT| < 20'h00400. First strobe output equals the unfiltered value.
